// File: rtl/alu_step_sequencer_if.sv
// Handshake and result bus between the microcode sequencer (master) and
// the multiply/divide step sequencer (slave).
interface alu_step_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             err;

    modport master (
        output start, op, a, b,
        input  busy, done, result_hi, result_lo, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_hi, result_lo, err
    );
endinterface

// File: rtl/alu_step_sequencer.sv
// Multi-cycle unsigned multiply / restoring divide sequencer.
// One (WIDTH+1)-bit add or subtract per clock. Result is {hi, lo}.
// Build option: define ALU_STEP_SEQ_DIV_EN to compile in the divide path;
// without it an op=1 request completes immediately with err=1 and zero results.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; results from the last operation held
// RUN   | one add/subtract step per cycle, cnt counts 0..WIDTH-1
// DONE  | one-cycle done pulse; a start here is accepted immediately
module alu_step_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_step_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] hi, hi_nxt;
    logic [WIDTH-1:0] lo, lo_nxt;
    logic [WIDTH-1:0] breg, breg_nxt;
    logic             err, err_nxt;

    // Shared (WIDTH+1)-bit adder: x + y + cin
    logic [WIDTH:0]   add_x, add_y, sum;
    logic             add_cin;

`ifdef ALU_STEP_SEQ_DIV_EN
    logic             op_r, op_nxt;
    logic [WIDTH:0]   rem;
`endif

    // State, step counter and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            breg  <= '0;
            err   <= 1'b0;
`ifdef ALU_STEP_SEQ_DIV_EN
            op_r  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            breg  <= breg_nxt;
            err   <= err_nxt;
`ifdef ALU_STEP_SEQ_DIV_EN
            op_r  <= op_nxt;
`endif
        end
    end

    // Next-state, adder operand selection and datapath update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        breg_nxt  = breg;
        err_nxt   = err;
        add_x     = {1'b0, hi};
        add_y     = {1'b0, (lo[0] ? breg : {WIDTH{1'b0}})};
        add_cin   = 1'b0;
`ifdef ALU_STEP_SEQ_DIV_EN
        op_nxt    = op_r;
        // Partial remainder after the left shift; its msb is the bit leaving hi
        rem       = {hi, lo[WIDTH-1]};
        if (op_r) begin
            add_x   = rem;
            add_y   = ~{1'b0, breg};
            add_cin = 1'b1;
        end
`endif
        sum = add_x + add_y + (WIDTH + 1)'(add_cin);

        case (state)
            IDLE, DONE: begin
                if (state == DONE) begin
                    state_nxt = IDLE;
                end
                if (bus.start) begin
                    breg_nxt  = bus.b;
                    err_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    hi_nxt    = '0;
                    lo_nxt    = bus.a;
                    state_nxt = RUN;
`ifdef ALU_STEP_SEQ_DIV_EN
                    op_nxt    = bus.op;
                    if (bus.op && (bus.b == '0)) begin
                        err_nxt   = 1'b1;
                        hi_nxt    = bus.a;
                        lo_nxt    = '1;
                        state_nxt = DONE;
                    end
`else
                    if (bus.op) begin
                        err_nxt   = 1'b1;
                        hi_nxt    = '0;
                        lo_nxt    = '0;
                        state_nxt = DONE;
                    end
`endif
                end
            end
            RUN: begin
                cnt_nxt = cnt + CNT_W'(1);
`ifdef ALU_STEP_SEQ_DIV_EN
                if (op_r) begin
                    // sum[WIDTH] set means the trial subtraction went negative
                    hi_nxt = sum[WIDTH] ? rem[WIDTH-1:0] : sum[WIDTH-1:0];
                    lo_nxt = {lo[WIDTH-2:0], ~sum[WIDTH]};
                end else begin
                    hi_nxt = sum[WIDTH:1];
                    lo_nxt = {sum[0], lo[WIDTH-1:1]};
                end
`else
                hi_nxt = sum[WIDTH:1];
                lo_nxt = {sum[0], lo[WIDTH-1:1]};
`endif
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decodes of the state and the raw result registers
    always_comb begin
        bus.busy      = (state == RUN);
        bus.done      = (state == DONE);
        bus.result_hi = hi;
        bus.result_lo = lo;
        bus.err       = err;
    end
endmodule
